pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-sequencing controller for the Pong overlay. Owns the match state machine (rule screen, serve delay, play, point scoring, game over), keeps both players' scores as BCD digit pairs, and drives the text overlay's four score digits and region enables. Sits between the button/ball-logic layer and the text/graphics renderers. All control is sampled on the 60 Hz frame `tick`.

## Interface
- `WIN_SCORE`, default 11: score that ends the match. Legal range 1..99.
- `SERVE_FRAMES`, default 120: frame ticks spent in SERVE (2 s at 60 Hz). Legal range 1..255.
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `tick`  in  1  one-cycle pulse per video frame
- `start_btn`  in  1  debounced start button, level
- `point_p1`  in  1  one-cycle pulse: player 1 scored
- `point_p2`  in  1  one-cycle pulse: player 2 scored
- `dig3`, `dig2`  out  4 each  player 1 score, tens and ones (BCD)
- `dig1`, `dig0`  out  4 each  player 2 score, tens and ones (BCD)
- `show_rule`  out  1  enable for the rule text region
- `show_over`  out  1  enable for the game-over text region
- `ball_reset`  out  1  hold ball and paddles at their serve positions
- `game_run`  out  1  ball motion enabled
- `winner`  out  2  01 = player 1, 10 = player 2, 00 = none

## Operation
- **States:** IDLE, SERVE, PLAY, POINT, OVER. Encoding is free. Reset state is IDLE.
- **Start detection:** `start_btn` is registered once internally. `start_edge` = current & ~previous.
- **IDLE:** `show_rule`=1 and `ball_reset`=1.
  - On `start_edge`: clear all digits, set `winner`=00, go to SERVE, and clear the serve counter.
- **SERVE:** `ball_reset`=1.
  - An 8-bit counter increments on each `tick`.
  - On the `tick` where the counter = SERVE_FRAMES-1, go to PLAY.
- **PLAY:** `game_run`=1.
  - `point_p1` alone: increment player 1's BCD pair, go to POINT.
  - `point_p2` alone: increment player 2's BCD pair, go to POINT.
  - Both in the same cycle: no score change, go to SERVE with the counter cleared (replay).
- **POINT:** lasts one cycle.
  - If either player's score = WIN_SCORE, set `winner` to that player and go to OVER.
  - Otherwise go to SERVE with the counter cleared.
- **OVER:** `show_over`=1 and `ball_reset`=1. Scores and `winner` are held.
  - On `start_edge`, go to IDLE. Digits stay visible until the next start clears them.
- **Ignored inputs:** points outside PLAY are ignored. `start_edge` outside IDLE and OVER is ignored.
- **BCD increment:** the ones digit wraps 9→0 and carries into tens. Tens never exceeds 9 because WIN_SCORE ≤ 99 ends the match first.
- **Derived outputs:** `show_rule`, `show_over`, `ball_reset` and `game_run` are decoded from the state register, so they are glitch-free and registered-equivalent.

## Timing
- **Reset values:** all digits 0, `winner`=00, state IDLE. This gives `show_rule`=1, `ball_reset`=1, `show_over`=0, `game_run`=0. The serve counter and the start register are 0.
- **Reset mid-operation:** asserting `reset_n` low in any state returns everything to the reset values immediately (asynchronous). The first start is accepted only on a fresh rising edge after release.
- **Start latency:** if `start_btn` rises at edge N, `start_edge` is seen at N+1. State is SERVE and digits are cleared after edge N+1.
- **Point latency:** a point pulse sampled at edge N in PLAY makes the digits update and state become POINT after N. State becomes SERVE or OVER after N+1. `winner` is valid with OVER.
- **Serve duration:** exactly SERVE_FRAMES `tick` pulses. With SERVE_FRAMES=1, the first `tick` in SERVE moves to PLAY.
- **Tick coincident with transition:** a `tick` in the same cycle SERVE is entered is not counted.

## Configuration
- **Macro:** `PONG_CTRL_AUTO_RESTART_EN`.
- **Defined:** OVER also returns to IDLE, without a button press, after SERVE_FRAMES×4 ticks, counted with a 10-bit counter cleared on OVER entry. `start_edge` still exits OVER early.
- **Undefined:** OVER is left only on `start_edge`. No extra counter is built.

## Test plan
- **Reset and start:** reset, release, raise `start_btn` → SERVE one cycle later, digits 0000. After 120 ticks → `game_run`=1.
- **BCD carry:** score player 2 ten times with WIN_SCORE=11 → dig1/dig0 go 0/9 → 1/0. No OVER.
- **Win:** player 1 reaches 11 → POINT then OVER, `winner`=01, `show_over`=1, dig3/dig2=1/1 held. Start press → IDLE with digits still 1/1. Next start → 0000.
- **Simultaneous points:** `point_p1` and `point_p2` together in PLAY → no digit change, SERVE. Points pulsed during SERVE/IDLE/OVER → ignored.
- **Reset mid-play:** `reset_n` low in PLAY with score 05:03 → immediately IDLE, 0000, `game_run`=0. Holding `start_btn` high through release does not start a game.
- **Auto-restart, macro defined:** in OVER, 480 ticks with no button → IDLE. Macro undefined: 1000 ticks → still OVER.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: rule screen, serve delay, play, point scoring, game over, BCD scores.
// Optional OVER timeout back to IDLE is built when PONG_CTRL_AUTO_RESTART_EN is defined.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       show_rule,
    output logic       show_over,
    output logic       ball_reset,
    output logic       game_run,
    output logic [1:0] winner,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0] WIN_TENS   = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_ONES   = 4'(WIN_SCORE % 10);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_start_q;
    logic       r_start_armed;
    logic       w_start_edge;
    logic [7:0] r_serve_cnt;
    logic [3:0] r_p1_tens;
    logic [3:0] r_p1_ones;
    logic [3:0] r_p2_tens;
    logic [3:0] r_p2_ones;
    logic [1:0] r_winner;

    logic       w_clr_scores;
    logic       w_clr_serve;
    logic       w_inc_p1;
    logic       w_inc_p2;
    logic       w_win_load;
    logic [1:0] w_win_val;
    logic       w_p1_win;
    logic       w_p2_win;
    logic [7:0] w_p1_next;
    logic [7:0] w_p2_next;

    // Ones digit wraps 9->0 and carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    // A start is only honoured once the button has been seen low since reset,
    // so a button held through reset release cannot launch a game.
    assign w_start_edge = start_btn & ~r_start_q & r_start_armed;
    assign w_p1_win     = (r_p1_tens == WIN_TENS) && (r_p1_ones == WIN_ONES);
    assign w_p2_win     = (r_p2_tens == WIN_TENS) && (r_p2_ones == WIN_ONES);
    assign w_p1_next    = bcd_inc(r_p1_tens, r_p1_ones);
    assign w_p2_next    = bcd_inc(r_p2_tens, r_p2_ones);

`ifdef PONG_CTRL_AUTO_RESTART_EN
    localparam logic [9:0] OVER_LAST = 10'(SERVE_FRAMES * 4 - 1);
    logic [9:0] r_over_cnt;
    logic       w_over_timeout;

    assign w_over_timeout = tick && (r_over_cnt == OVER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_over_cnt <= 10'd0;
        end else if (r_state != ST_OVER) begin
            r_over_cnt <= 10'd0;
        end else if (tick) begin
            r_over_cnt <= r_over_cnt + 10'd1;
        end
    end
`else
    logic w_over_timeout;
    assign w_over_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_scores = 1'b0;
        w_clr_serve  = 1'b0;
        w_inc_p1     = 1'b0;
        w_inc_p2     = 1'b0;
        w_win_load   = 1'b0;
        w_win_val    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_clr_scores = 1'b1;
                    w_clr_serve  = 1'b1;
                    w_next_state = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick && (r_serve_cnt == SERVE_LAST)) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                case ({point_p1, point_p2})
                    2'b10: begin
                        w_inc_p1     = 1'b1;
                        w_next_state = ST_POINT;
                    end
                    2'b01: begin
                        w_inc_p2     = 1'b1;
                        w_next_state = ST_POINT;
                    end
                    2'b11: begin
                        w_clr_serve  = 1'b1;
                        w_next_state = ST_SERVE;
                    end
                    default: ;
                endcase
            end
            ST_POINT: begin
                if (w_p1_win) begin
                    w_win_load   = 1'b1;
                    w_win_val    = 2'b01;
                    w_next_state = ST_OVER;
                end else if (w_p2_win) begin
                    w_win_load   = 1'b1;
                    w_win_val    = 2'b10;
                    w_next_state = ST_OVER;
                end else begin
                    w_clr_serve  = 1'b1;
                    w_next_state = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (w_start_edge || w_over_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q     <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_start_q     <= start_btn;
            r_start_armed <= r_start_armed | ~start_btn;
        end
    end

    // The state check keeps the tick that coincides with SERVE entry from counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_serve_cnt <= 8'd0;
        end else if (w_clr_serve) begin
            r_serve_cnt <= 8'd0;
        end else if ((r_state == ST_SERVE) && tick) begin
            r_serve_cnt <= r_serve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_tens <= 4'd0;
            r_p1_ones <= 4'd0;
            r_p2_tens <= 4'd0;
            r_p2_ones <= 4'd0;
            r_winner  <= 2'b00;
        end else begin
            if (w_clr_scores) begin
                r_p1_tens <= 4'd0;
                r_p1_ones <= 4'd0;
                r_p2_tens <= 4'd0;
                r_p2_ones <= 4'd0;
                r_winner  <= 2'b00;
            end else begin
                if (w_inc_p1) begin
                    {r_p1_tens, r_p1_ones} <= w_p1_next;
                end
                if (w_inc_p2) begin
                    {r_p2_tens, r_p2_ones} <= w_p2_next;
                end
                if (w_win_load) begin
                    r_winner <= w_win_val;
                end
            end
        end
    end

    assign dig3       = r_p1_tens;
    assign dig2       = r_p1_ones;
    assign dig1       = r_p2_tens;
    assign dig0       = r_p2_ones;
    assign winner     = r_winner;
    assign show_rule  = (r_state == ST_IDLE);
    assign show_over  = (r_state == ST_OVER);
    assign ball_reset = (r_state == ST_IDLE) || (r_state == ST_SERVE) || (r_state == ST_OVER);
    assign game_run   = (r_state == ST_PLAY);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl with a behavioural match model and expected-snapshot queue.
module tb_pong_game_ctrl;

  localparam int WIN = 11;
  localparam int SF  = 120;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       show_rule, show_over, ball_reset, game_run;
  logic [1:0] winner;
  logic [2:0] dbg_state;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start_btn(start_btn),
    .point_p1(point_p1), .point_p2(point_p2),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .show_rule(show_rule), .show_over(show_over), .ball_reset(ball_reset),
    .game_run(game_run), .winner(winner), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] exp_q[$];
  string       tag_q[$];

  int         m_st = M_IDLE;
  int         m_p1 = 0;
  int         m_p2 = 0;
  logic [1:0] m_win = 2'b00;

  function automatic logic [21:0] model_snap();
    logic [15:0] d;
    logic [3:0]  f;
    d = {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10)};
    f = {m_st == M_IDLE, m_st == M_OVER,
         (m_st == M_IDLE) || (m_st == M_SERVE) || (m_st == M_OVER), m_st == M_PLAY};
    return {d, f, m_win};
  endfunction

  function automatic logic [21:0] dut_snap();
    return {dig3, dig2, dig1, dig0, show_rule, show_over, ball_reset, game_run, winner};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_q.push_back(model_snap());
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [21:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {10'd0, dut_snap()}, {10'd0, e});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag);
    push_exp(tag);
    step();
    pop_check();
  endtask

  task automatic serve_phase(input string tag);
    bit chk;
    for (int i = 0; i < SF; i++) begin
      tick = 1'b1;
      chk = (i == SF - 2) || (i == SF - 1);
      if (i == SF - 1) m_st = M_PLAY;
      if (chk) push_exp({tag, (i == SF - 1) ? "_play" : "_still_serve"});
      step();
      tick = 1'b0;
      if (chk) pop_check();
      step();
    end
  endtask

  task automatic press_start(input string tag);
    start_btn = 1'b1;
    if (m_st == M_IDLE) begin
      m_p1 = 0; m_p2 = 0; m_win = 2'b00; m_st = M_SERVE;
    end else if (m_st == M_OVER) begin
      m_st = M_IDLE;
    end
    cycle(tag);
    start_btn = 1'b0;
    step();
  endtask

  task automatic score(input int who, input bit tick_in_point);
    if (who == 1) point_p1 = 1'b1; else point_p2 = 1'b1;
    if (who == 1) m_p1++; else m_p2++;
    m_st = M_POINT;
    cycle($sformatf("point_p%0d_%0d_%0d", who, m_p1, m_p2));
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    tick = tick_in_point;
    if (m_p1 == WIN) begin
      m_st = M_OVER; m_win = 2'b01;
    end else if (m_p2 == WIN) begin
      m_st = M_OVER; m_win = 2'b10;
    end else begin
      m_st = M_SERVE;
    end
    cycle("after_point");
    tick = 1'b0;
    if (m_st == M_SERVE) serve_phase("serve");
  endtask

  initial begin
    // Reset and idle behaviour
    step(); step();
    cycle("reset_state");
    reset_n = 1'b1;
    step();
    point_p1 = 1'b1; point_p2 = 1'b1;
    cycle("idle_points_ignored");
    point_p1 = 1'b0; point_p2 = 1'b0;
    tick = 1'b1;
    cycle("idle_tick_ignored");
    tick = 1'b0;

    press_start("start_to_serve");
    point_p1 = 1'b1;
    cycle("serve_point_ignored");
    point_p1 = 1'b0;
    press_start("serve_start_ignored");
    serve_phase("first_serve");

    // BCD carry on player 2
    for (int k = 0; k < 10; k++) score(2, k == 3);

    // Replay on simultaneous points
    point_p1 = 1'b1; point_p2 = 1'b1;
    m_st = M_SERVE;
    cycle("replay_both_points");
    point_p1 = 1'b0; point_p2 = 1'b0;
    serve_phase("replay_serve");

    // Player 1 wins 11:10
    for (int k = 0; k < WIN; k++) score(1, 1'b0);
    point_p2 = 1'b1;
    cycle("over_point_ignored");
    point_p2 = 1'b0;

    // OVER timeout (only when auto-restart is built)
    for (int i = 0; i < 1000; i++) begin
      bit chk;
      tick = 1'b1;
      chk = (i == 4 * SF - 2) || (i == 4 * SF - 1) || (i == 999);
`ifdef PONG_CTRL_AUTO_RESTART_EN
      if (i == 4 * SF - 1) m_st = M_IDLE;
`endif
      if (chk) push_exp($sformatf("over_tick_%0d", i + 1));
      step();
      tick = 1'b0;
      if (chk) pop_check();
      step();
    end
    if (m_st == M_OVER) press_start("over_start_to_idle");
    cycle("idle_digits_held");
    press_start("restart_clears");
    serve_phase("serve2");

    // Reset in the middle of a 05:03 game, start held through release
    for (int k = 0; k < 5; k++) score(1, 1'b0);
    for (int k = 0; k < 3; k++) score(2, 1'b0);
    start_btn = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    m_st = M_IDLE; m_p1 = 0; m_p2 = 0; m_win = 2'b00;
    push_exp("async_reset_midplay");
    pop_check();
    step(); step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    cycle("held_start_no_game_a");
    cycle("held_start_no_game_b");
    start_btn = 1'b0;
    cycle("start_released");
    press_start("fresh_start_after_reset");

    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
